// File: rtl/pwm_duty_ctrl.sv
// Push-button duty-cycle controller: debounces up/down buttons, steps a saturating
// duty register once per press and auto-repeats while a button stays held.
module pwm_duty_ctrl #(
  parameter int unsigned DUTY_W          = 8,
  parameter int unsigned DUTY_INIT       = 128,
  parameter int unsigned DUTY_STEP       = 16,
  parameter int unsigned DUTY_MAX        = 255,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_dn,
  output logic [DUTY_W-1:0] duty,
  output logic              step_up,
  output logic              step_dn,
  output logic              at_limit
);

  localparam int unsigned CNT_MAX =
    (DEBOUNCE_CYCLES > REPEAT_DELAY)
      ? ((DEBOUNCE_CYCLES > REPEAT_RATE) ? DEBOUNCE_CYCLES : REPEAT_RATE)
      : ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]  RR_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [DUTY_W-1:0] MAX_V   = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] STEP_V  = DUTY_W'(DUTY_STEP);
  localparam logic [DUTY_W-1:0] UP_LIM  = DUTY_W'(DUTY_MAX - DUTY_STEP);
  localparam logic [DUTY_W-1:0] INIT_V  = DUTY_W'(DUTY_INIT);
  localparam logic              INIT_LIM = (DUTY_INIT == 0) || (DUTY_INIT == DUTY_MAX);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS_DB = 3'd1,
    S_HOLD     = 3'd2,
    S_REPEAT   = 3'd3,
    S_REL_DB   = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dir;
  logic [DUTY_W-1:0]  r_duty;
  logic               r_step_up;
  logic               r_step_dn;
  logic               r_at_limit;

  logic               w_sel;
  logic               w_other;
  logic               w_fire;
  logic [DUTY_W-1:0]  w_duty_up;
  logic [DUTY_W-1:0]  w_duty_dn;
  logic [DUTY_W-1:0]  w_duty_nxt;

  // r_dir: 1 = up button latched, 0 = down button latched
  always_comb begin
    w_sel   = r_dir ? btn_up : btn_dn;
    w_other = r_dir ? btn_dn : btn_up;
    w_fire  = 1'b0;
    case (r_state)
      S_PRESS_DB: w_fire = w_sel && !w_other && (r_cnt == DB_LAST);
      S_HOLD:     w_fire = w_sel && (r_cnt == RD_LAST);
      S_REPEAT:   w_fire = w_sel && (r_cnt == RR_LAST);
      default:    w_fire = 1'b0;
    endcase
  end

  // Saturation is tested before the add/subtract so the result never wraps at DUTY_W bits
  always_comb begin
    w_duty_up  = (r_duty > UP_LIM) ? MAX_V : r_duty + STEP_V;
    w_duty_dn  = (r_duty < STEP_V) ? '0 : r_duty - STEP_V;
    w_duty_nxt = r_dir ? w_duty_up : w_duty_dn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dir      <= 1'b0;
      r_duty     <= INIT_V;
      r_step_up  <= 1'b0;
      r_step_dn  <= 1'b0;
      r_at_limit <= INIT_LIM;
    end else begin
      r_step_up <= w_fire & r_dir;
      r_step_dn <= w_fire & ~r_dir;
      if (w_fire) begin
        r_duty     <= w_duty_nxt;
        r_at_limit <= (w_duty_nxt == '0) || (w_duty_nxt == MAX_V);
      end

      case (r_state)
        S_IDLE: begin
          if (btn_up ^ btn_dn) begin
            r_dir   <= btn_up;
            r_cnt   <= '0;
            r_state <= S_PRESS_DB;
          end
        end
        S_PRESS_DB: begin
          if (!w_sel || w_other) begin
            r_state <= S_IDLE;
          end else if (r_cnt == DB_LAST) begin
            r_cnt   <= '0;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (!w_sel) begin
            r_cnt   <= '0;
            r_state <= S_REL_DB;
          end else if (r_cnt == RD_LAST) begin
            r_cnt   <= '0;
            r_state <= S_REPEAT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!w_sel) begin
            r_cnt   <= '0;
            r_state <= S_REL_DB;
          end else if (r_cnt == RR_LAST) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_REL_DB: begin
          if (w_sel) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign duty     = r_duty;
  assign step_up  = r_step_up;
  assign step_dn  = r_step_dn;
  assign at_limit = r_at_limit;

endmodule
